// File: rtl/vga_frame_checker.sv
// VGA timing and content checker: measures line/sync/frame timing from the hs/vs taps,
// computes a per-frame CRC-16-CCITT of pixel data and reports per-frame results plus lock.
module vga_frame_checker #(
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EXP_HTOTAL  = 1344,
    parameter int unsigned EXP_VTOTAL  = 806,
    parameter int unsigned EXP_HSYNC_W = 136,
    parameter int unsigned EXP_VSYNC_W = 6,
    parameter logic        SYNC_POL    = 1'b1,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hs,
    input  logic               vs,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic               frame_done,
    output logic [CNT_W-1:0]   meas_htotal,
    output logic [CNT_W-1:0]   meas_hsync_w,
    output logic [CNT_W-1:0]   meas_vtotal,
    output logic [CNT_W-1:0]   meas_vsync_w,
    output logic [15:0]        frame_crc,
    output logic               err_htotal,
    output logic               err_hsync,
    output logic               err_vtotal,
    output logic               err_vsync,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               locked
);

    localparam int unsigned      PIX_W  = 3 * COLOR_W;
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, MEASURE} state_t;
    state_t state, state_nxt;

    logic             hs_q, vs_q, hs_p, vs_p;
    logic [PIX_W-1:0] pix_q;
    logic             hs_act, vs_act, hs_rise, hs_fall, vs_rise;
    logic             idle, start, meas, close;

    logic [CNT_W-1:0] pix_cnt, hw_cnt, line_cnt, vsl_cnt, clean_cnt, clean_nxt;
    logic [15:0]      crc;
    logic             line_valid, hw_valid, eh_acc, ehs_acc;
    logic             h_chk, h_bad, w_chk, w_bad, v_bad, vs_bad, any_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    // A saturated count never matches, even if the expectation equals the max.
    function automatic logic mismatch(input logic [CNT_W-1:0] cnt, input int unsigned expv);
        return (cnt != CNT_W'(expv)) || (cnt == '1);
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [PIX_W-1:0] d);
        logic [15:0]      c;
        logic [PIX_W-1:0] dd;
        logic             fb;
        c  = c_in;
        dd = d;
        for (int unsigned i = 0; i < PIX_W; i++) begin
            fb = c[15] ^ dd[PIX_W-1];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            dd = dd << 1;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            hs_p  <= 1'b0;
            vs_p  <= 1'b0;
            pix_q <= '0;
        end else begin
            hs_q  <= hs;
            vs_q  <= vs;
            hs_p  <= hs_q;
            vs_p  <= vs_q;
            pix_q <= {r, g, b};
        end
    end

    assign hs_act  = (hs_q == SYNC_POL);
    assign vs_act  = (vs_q == SYNC_POL);
    assign hs_rise = hs_act && (hs_p != SYNC_POL);
    assign hs_fall = !hs_act && (hs_p == SYNC_POL);
    assign vs_rise = vs_act && (vs_p != SYNC_POL);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:       state_nxt = WAIT_FRAME;
                WAIT_FRAME: if (vs_rise) state_nxt = MEASURE;
                MEASURE:    state_nxt = MEASURE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        idle  = (state == IDLE);
        start = (state == WAIT_FRAME) && en && vs_rise;
        meas  = (state == MEASURE) && en;
        close = meas && vs_rise;
    end

    assign h_chk   = meas && hs_rise && line_valid;
    assign h_bad   = mismatch(pix_cnt, EXP_HTOTAL);
    assign w_chk   = meas && hs_fall && hw_valid;
    assign w_bad   = mismatch(hw_cnt, EXP_HSYNC_W);
    assign v_bad   = mismatch(line_cnt, EXP_VTOTAL);
    assign vs_bad  = mismatch(vsl_cnt, EXP_VSYNC_W);
    assign any_err = eh_acc | ehs_acc | v_bad | vs_bad;

    always_comb begin
        clean_nxt = clean_cnt;
        if (any_err)                clean_nxt = '0;
        else if (clean_cnt != LOCK_V) clean_nxt = clean_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done   <= 1'b0;
            meas_htotal  <= '0;
            meas_hsync_w <= '0;
            meas_vtotal  <= '0;
            meas_vsync_w <= '0;
            frame_crc    <= '0;
            err_htotal   <= 1'b0;
            err_hsync    <= 1'b0;
            err_vtotal   <= 1'b0;
            err_vsync    <= 1'b0;
            err_cnt      <= '0;
            frame_cnt    <= '0;
            locked       <= 1'b0;
            pix_cnt      <= '0;
            hw_cnt       <= '0;
            line_cnt     <= '0;
            vsl_cnt      <= '0;
            clean_cnt    <= '0;
            crc          <= '0;
            line_valid   <= 1'b0;
            hw_valid     <= 1'b0;
            eh_acc       <= 1'b0;
            ehs_acc      <= 1'b0;
        end else begin
            frame_done <= close;
            if (idle) begin
                locked    <= 1'b0;
                clean_cnt <= '0;
            end
            if (start) begin
                line_valid <= 1'b0;
                hw_valid   <= 1'b0;
                pix_cnt    <= '0;
                hw_cnt     <= '0;
                line_cnt   <= '0;
                vsl_cnt    <= '0;
                eh_acc     <= 1'b0;
                ehs_acc    <= 1'b0;
                crc        <= crc_step(16'hFFFF, pix_q);
            end
            if (meas) begin
                pix_cnt <= hs_rise ? CNT_W'(1) : sat_inc(pix_cnt);
                hw_cnt  <= hs_rise ? CNT_W'(1) : (hs_act ? sat_inc(hw_cnt) : hw_cnt);
                if (hs_rise) begin
                    line_valid <= 1'b1;
                    hw_valid   <= 1'b1;
                end
                if (h_chk) meas_htotal  <= pix_cnt;
                if (w_chk) meas_hsync_w <= hw_cnt;
                // On close, an hs edge or hs trailing edge in the same cycle belongs to the new frame.
                if (close) begin
                    meas_vtotal  <= line_cnt;
                    meas_vsync_w <= vsl_cnt;
                    frame_crc    <= crc;
                    err_htotal   <= eh_acc;
                    err_hsync    <= ehs_acc;
                    err_vtotal   <= v_bad;
                    err_vsync    <= vs_bad;
                    eh_acc       <= h_chk && h_bad;
                    ehs_acc      <= w_chk && w_bad;
                    line_cnt     <= hs_rise ? CNT_W'(1) : '0;
                    vsl_cnt      <= hs_rise ? CNT_W'(1) : '0;
                    crc          <= crc_step(16'hFFFF, pix_q);
                    frame_cnt    <= frame_cnt + 1'b1;
                    if (any_err) err_cnt <= sat_inc(err_cnt);
                    clean_cnt    <= clean_nxt;
                    locked       <= (clean_nxt == LOCK_V);
                end else begin
                    eh_acc  <= eh_acc | (h_chk && h_bad);
                    ehs_acc <= ehs_acc | (w_chk && w_bad);
                    if (hs_rise)           line_cnt <= sat_inc(line_cnt);
                    if (hs_rise && vs_act) vsl_cnt  <= sat_inc(vsl_cnt);
                    crc <= crc_step(crc, pix_q);
                end
            end
        end
    end

endmodule
